// File: rtl/store_align_if.sv
// Store request and memory write-beat bundle for store_align_unit.
// master: datapath + memory side; slave: store_align_unit.
interface store_align_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BYTES = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BYTES-1:0]  mem_be;
    logic              st_done;
    logic              st_err;

    modport master (
        output req_valid, req_size, req_addr, req_wdata, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be,
        input  st_done, st_err
    );

    modport slave (
        input  req_valid, req_size, req_addr, req_wdata, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_be,
        output st_done, st_err
    );
endinterface

// File: rtl/store_align_unit.sv
// Store path: turns one store request into one or two aligned write beats.
// Ports: clk, rst_n (async active-low), bus (store_align_if.slave).
module store_align_unit #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter bit ALLOW_UNALIGNED = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    store_align_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;

    logic [1:0]        r_state;
    logic              r_split;
    logic              r_mem_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [BYTES-1:0]  r_mem_be;
    logic [ADDR_W-1:0] r_addr1;
    logic [DATA_W-1:0] r_wdata1;
    logic [BYTES-1:0]  r_be1;
    logic              r_done;
    logic              r_err;

    logic [OFF_W-1:0]    w_off;
    logic [4:0]          w_nbytes;
    logic [4:0]          w_end;
    logic [ADDR_W-1:0]   w_base;
    logic                w_too_big;
    logic                w_misal;
    logic                w_illegal;
    logic                w_split;
    logic [2*BYTES-1:0]  w_be_wide;
    logic [2*DATA_W-1:0] w_wd_wide;

    assign w_off     = bus.req_addr[OFF_W-1:0];
    assign w_nbytes  = 5'd1 << bus.req_size;
    assign w_end     = 5'(w_off) + w_nbytes;
    assign w_base    = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_too_big = w_nbytes > 5'(BYTES);
    assign w_misal   = (5'(w_off) & (w_nbytes - 5'd1)) != 5'd0;
    assign w_illegal = w_too_big || (!ALLOW_UNALIGNED && w_misal);
    assign w_split   = w_end > 5'(BYTES);

    // Shift across a double-width window: the low half is beat 0,
    // the high half is whatever spills into the next word (beat 1).
    assign w_be_wide = (((2*BYTES)'(1) << w_nbytes) - (2*BYTES)'(1))
                       << w_off;
    assign w_wd_wide = {{DATA_W{1'b0}}, bus.req_wdata}
                       << {w_off, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_split     <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_addr1     <= '0;
            r_wdata1    <= '0;
            r_be1       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state     <= S_BEAT0;
                            r_split     <= w_split;
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= w_base;
                            r_mem_be    <= w_be_wide[BYTES-1:0];
                            r_mem_wdata <= w_wd_wide[DATA_W-1:0];
                            r_addr1     <= w_base + ADDR_W'(BYTES);
                            r_be1       <= w_be_wide[2*BYTES-1:BYTES];
                            r_wdata1    <= w_wd_wide[2*DATA_W-1:DATA_W];
                        end
                    end
                end
                S_BEAT0: begin
                    if (bus.mem_ready) begin
                        if (r_split) begin
                            r_state     <= S_BEAT1;
                            r_mem_addr  <= r_addr1;
                            r_mem_be    <= r_be1;
                            r_mem_wdata <= r_wdata1;
                        end else begin
                            r_state     <= S_IDLE;
                            r_mem_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                S_BEAT1: begin
                    if (bus.mem_ready) begin
                        r_state     <= S_IDLE;
                        r_mem_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;
    assign bus.st_done   = r_done;
    assign bus.st_err    = r_err;
endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
Parametrised store path between the datapath and the data-memory bus for the multicycle CPU. It accepts one store request (address, size, raw register data) and converts it into one or two aligned memory write beats. Each beat carries a word-aligned address, lane-shifted write data and byte enables. Misaligned stores are either split across two words or rejected with an alignment error, selected by parameter. It generalises the combinational SB/SH/SW byte-enable decode to any bus width, adds data lane steering, adds a ready/valid handshake, and adds the split-transaction FSM.

Parameters:
DATA_W, 32, memory bus width in bits; 32 or 64. BYTES = DATA_W/8. OFF_W = log2(BYTES).
ADDR_W, 32, byte-address width.
ALLOW_UNALIGNED, 1, 1 = split a misaligned store into two beats; 0 = reject it with st_err.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset; asynchronous, active-low.
req_valid  in  1  store request valid.
req_ready  out  1  unit can accept a request; equals (state==IDLE).
req_size  in  2  00 byte, 01 half, 10 word, 11 dword (dword is legal only when DATA_W=64).
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, right-justified.
mem_valid  out  1  write beat valid.
mem_ready  in  1  memory accepts the beat.
mem_addr  out  ADDR_W  beat address, low OFF_W bits always 0.
mem_wdata  out  DATA_W  lane-aligned write data.
mem_be  out  BYTES  byte enables, bit i = byte lane i.
st_done  out  1  one-cycle pulse: store fully written.
st_err  out  1  one-cycle pulse: request rejected (illegal size or misalignment).

Behaviour:
- Reset (rst_n=0, applied asynchronously):
  - state = IDLE.
  - mem_valid, mem_addr, mem_wdata, mem_be, st_done, st_err all 0.
  - req_ready = 1.
- All mem_* outputs, st_done and st_err are registered. req_ready is decoded from state.
- Accept condition: req_valid && req_ready in IDLE. Define N = 1<<req_size, off = req_addr[OFF_W-1:0], base = req_addr with the low OFF_W bits cleared.
- Illegal request: N > BYTES, or (off % N != 0 and ALLOW_UNALIGNED=0).
  - st_err=1 for the next cycle only.
  - No memory beat is issued.
  - State stays IDLE.
- Single beat (off + N <= BYTES):
  - mem_addr = base.
  - mem_be = ((1<<N)-1) << off.
  - mem_wdata = req_wdata << 8*off, truncated to DATA_W.
  - Next state BEAT0, split=0.
- Split (off + N > BYTES, ALLOW_UNALIGNED=1):
  - Beat 0: mem_addr = base; mem_be = lanes off..BYTES-1; mem_wdata = req_wdata << 8*off.
  - Beat 1 fields are computed and held internally: addr = base + BYTES; be = lanes 0..(off+N-BYTES-1); wdata = req_wdata >> 8*(BYTES-off).
  - Next state BEAT0, split=1.
- BEAT0 / BEAT1:
  - mem_valid=1. mem_addr, mem_wdata and mem_be stay stable until mem_ready.
  - On mem_ready in BEAT0: if split, go to BEAT1 and load the beat-1 fields the next cycle. Otherwise clear mem_valid, pulse st_done and return to IDLE.
  - On mem_ready in BEAT1: clear mem_valid, pulse st_done and return to IDLE.
- Latency with mem_ready tied high:
  - Aligned store: accept at T, beat at T+1, st_done and req_ready at T+2.
  - Split store: one extra cycle.
- A new request may be accepted in the same cycle st_done is high, because state is already IDLE.
- mem_valid never drops without a handshake, except on reset.
- Reset mid-transaction aborts immediately: mem_valid falls asynchronously and a pending beat 1 is discarded.
- A request presented while req_ready=0 is ignored; the requester must hold it.
- Address arithmetic for base+BYTES wraps modulo 2^ADDR_W.

Test Plan:
All cases use DATA_W=32 unless stated.
1. Byte store: size 00, addr 0x1003, wdata 0x000000AB → one beat: mem_addr 0x1000, be 1000, wdata 0xAB000000; st_done one cycle after the handshake.
2. Half store: size 01, addr 0x2002, wdata 0x00001234 → be 1100, wdata 0x12340000. Repeat with addr 0x2000 → be 0011, wdata 0x00001234.
3. Split word store, ALLOW_UNALIGNED=1: size 10, addr 0x3001, wdata 0xAABBCCDD → beat 0: 0x3000, be 1110, wdata 0xBBCCDD00; beat 1: 0x3004, be 0001, wdata 0x000000AA; exactly one st_done.
4. Rejected store: same request as case 3 with ALLOW_UNALIGNED=0 → st_err pulses once, mem_valid stays 0. Separately, size 11 with DATA_W=32 → st_err.
5. Backpressure: hold mem_ready=0 for 3 cycles during beat 0 of case 3 → mem_* outputs stable, req_ready=0, and a second req_valid is ignored until st_done.
6. Reset mid-split: drive rst_n low in BEAT1 → mem_valid=0 asynchronously; after release, state is IDLE, req_ready=1 and no st_done is produced. For DATA_W=64, dword at addr 0x6 → beat 0 be 0xC0, beat 1 be 0x3F.
